// File: rtl/jk_bank_pkg.sv
// Purpose: shared command codes and FSM state encoding for the JK bank arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package jk_bank_pkg;

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/jk_ff_bank.sv
// Purpose: WIDTH independent JK flip-flops with complementary outputs.
// Latency: q follows J/K one clock edge later; q_bar is combinational from q.
// Backpressure: none; J/K are acted on every edge.
module jk_ff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // JK characteristic equation per bit: set on J, clear on K, toggle on both.
    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    // Bank register; async reset drives every bit to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Purpose: round-robin arbiter letting NUM_REQ requesters issue masked JK commands to one bank.
// Latency: sample at E0, q updates at E1, gnt pulses between E1 and E2; one command per 3 cycles.
// Backpressure: req is a level held until its gnt; losers simply wait in IDLE re-arbitration.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     cmd,
    input  logic [WIDTH*NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         q_bar
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    // Requester index 'off' places above base, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin pick: scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[rot_idx(rr_ptr_q, off)]) begin
                pick_vld = 1'b1;
                pick_idx = rot_idx(rr_ptr_q, off);
            end
        end
    end

    // FSM next state, latches, J/K decode and handshake outputs.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        cmd_d    = cmd_q;
        mask_d   = mask_q;
        j        = '0;
        k        = '0;
        gnt      = '0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    win_d   = pick_idx;
                    cmd_d   = cmd[2*int'(pick_idx) +: 2];
                    mask_d  = mask[WIDTH*int'(pick_idx) +: WIDTH];
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                // Unmasked bits stay at J=K=0 so they hold.
                if (cmd_q == CMD_SET || cmd_q == CMD_TOGGLE) begin
                    j = mask_q;
                end
                if (cmd_q == CMD_RESET || cmd_q == CMD_TOGGLE) begin
                    k = mask_q;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                gnt[win_q] = 1'b1;
                rr_ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state; reset discards any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            cmd_q    <= CMD_HOLD;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            cmd_q    <= cmd_d;
            mask_q   <= mask_d;
        end
    end

    jk_ff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .j     (j),
        .k     (k),
        .q     (q),
        .q_bar (q_bar)
    );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Purpose: self-checking bench for jk_bank_arbiter against a transaction-level model.
// Latency: model predicts q/gnt/busy per cycle; compared on every falling edge.
// Backpressure: requesters hold req until granted, then drop.
module tb_jk_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [2*N-1:0] cmd;
    logic [W*N-1:0] mask;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   q;
    logic [W-1:0]   q_bar;

    always #5 clk = ~clk;

    jk_bank_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .cmd   (cmd),
        .mask  (mask),
        .gnt   (gnt),
        .busy  (busy),
        .q     (q),
        .q_bar (q_bar)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a command occupies three cycles (sample, apply, grant); bank state as plain mask math.
    logic [W-1:0] m_q;
    int           m_ptr;
    int           m_phase;
    int           m_win;
    logic [1:0]   m_cmd;
    logic [W-1:0] m_mask;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) begin
            if (r[(p + o) % N]) return (p + o) % N;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] apply_cmd(input logic [W-1:0] cur, input logic [1:0] c,
                                               input logic [W-1:0] m);
        case (c)
            2'b01:   return cur & ~m;
            2'b10:   return cur | m;
            2'b11:   return cur ^ m;
            default: return cur;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q     <= '0;
            m_ptr   <= 0;
            m_phase <= 0;
            m_win   <= 0;
            m_cmd   <= 2'b00;
            m_mask  <= '0;
        end else begin
            case (m_phase)
                0: if (req != '0) begin
                    m_win   <= pick(req, m_ptr);
                    m_cmd   <= cmd[2*pick(req, m_ptr) +: 2];
                    m_mask  <= mask[W*pick(req, m_ptr) +: W];
                    m_phase <= 1;
                end
                1: begin
                    m_q     <= apply_cmd(m_q, m_cmd, m_mask);
                    m_phase <= 2;
                end
                default: begin
                    m_ptr   <= (m_win + 1) % N;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("gnt",   32'(gnt),   (m_phase == 2) ? (32'd1 << m_win) : 32'd0);
        chk("busy",  32'(busy),  32'(m_phase != 0));
        chk("q",     32'(q),     32'(m_q));
        chk("q_bar", 32'(q_bar), 32'(m_q ^ {W{1'b1}}));
    end

    int ng;
    int nb;
    int order[$];
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int first_win;
    int gnt_seen;

    // One full handshake from requester i; counts grant pulses and busy cycles seen.
    task automatic txn(input int i, input logic [1:0] c, input logic [W-1:0] m,
                       output int g_cnt, output int b_cnt);
        g_cnt = 0;
        b_cnt = 0;
        @(negedge clk);
        #1;
        req[i] = 1'b1;
        cmd[2*i +: 2] = c;
        mask[W*i +: W] = m;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (busy) b_cnt++;
            if (gnt == (4'b0001 << i)) g_cnt++;
            if (gnt[i]) begin
                #1;
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] reraise;
        rst  = 1'b1;
        req  = '0;
        cmd  = '0;
        mask = '0;
        repeat (2) @(negedge clk);
        chk("rst_q",     32'(q),     32'h00);
        chk("rst_q_bar", 32'(q_bar), 32'hFF);
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        #1 rst = 1'b0;

        txn(0, 2'b10, 8'h0F, ng, nb);
        chk("set0_q",    32'(q), 32'h0F);
        chk("set0_gnt",  ng, 1);
        chk("set0_busy", nb, 2);
        txn(1, 2'b11, 8'hFF, ng, nb);
        chk("tog1_q", 32'(q), 32'hF0);
        txn(3, 2'b01, 8'hC0, ng, nb);
        chk("rst3_q",     32'(q),     32'h30);
        chk("rst3_q_bar", 32'(q_bar), 32'hCF);
        txn(2, 2'b00, 8'hFF, ng, nb);
        chk("hold2_q",   32'(q), 32'h30);
        chk("hold2_gnt", ng, 1);
        txn(2, 2'b10, 8'h00, ng, nb);
        chk("nomask2_q",   32'(q), 32'h30);
        chk("nomask2_gnt", ng, 1);

        // Round-robin from rr_ptr=0 with every requester continuously re-requesting.
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        cmd     = {2'b11, 2'b11, 2'b11, 2'b11};
        mask    = {8'h08, 8'h04, 8'h02, 8'h01};
        req     = 4'hF;
        reraise = '0;
        for (int t = 0; t < 40 && order.size() < 5; t++) begin
            @(negedge clk);
            g = gnt;
            #1;
            req = req | reraise;
            reraise = '0;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    order.push_back(i);
                    req[i] = 1'b0;
                    reraise[i] = 1'b1;
                end
            end
        end
        chk("rr_count", order.size(), 5);
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("rr_order%0d", n), (n < order.size()) ? order[n] : 99, rr_exp[n]);
        end
        req = '0;
        repeat (6) @(negedge clk);

        // Reset while the command sits in ACK: q cleared, no grant, pointer back to 0.
        txn(2, 2'b00, 8'h00, ng, nb);
        @(negedge clk);
        #1;
        req[0] = 1'b1;
        cmd[1:0] = 2'b10;
        mask[7:0] = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("ack_q_pre",  32'(q),    32'hFF);
        chk("ack_gnt_pre", 32'(gnt), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_q",     32'(q),     32'h00);
        chk("mid_rst_q_bar", 32'(q_bar), 32'hFF);
        chk("mid_rst_gnt",   32'(gnt),   32'h0);
        chk("mid_rst_busy",  32'(busy),  32'h0);
        req[0] = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        gnt_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (gnt != '0) gnt_seen++;
        end
        chk("no_gnt_after_rst", gnt_seen, 0);
        #1;
        cmd  = '0;
        mask = '0;
        req  = 4'b1010;
        first_win = 99;
        for (int t = 0; t < 12 && first_win == 99; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (gnt[i]) first_win = i;
        end
        chk("post_rst_winner", first_win, 1);
        #1 req = '0;
        repeat (6) @(negedge clk);

        // Randomized requesters, including withdrawal after the command is latched.
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_phase == 2 && m_win == i) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    cmd[2*i +: 2]  = 2'($urandom_range(3));
                    mask[W*i +: W] = W'($urandom_range(255));
                    req[i] = 1'b1;
                end
            end
            if (m_phase == 1 && $urandom_range(7) == 0) req[m_win] = 1'b0;
        end
        req = '0;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of JK flip-flops among NUM_REQ requesters.
- Each requester issues a JK command (hold/reset/set/toggle) with a bit mask over a req/gnt handshake.
- A round-robin arbiter picks one request at a time and drives per-bit J/K for exactly one clock edge.
- It sits between control logic and the JK register datapath, as that datapath's sole writer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK flip-flops in the bank.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  request per requester; level, held until own gnt.
- cmd  in  2*NUM_REQ  command per requester, bits [2i+1:2i]; must be stable while req[i]=1.
- mask  in  WIDTH*NUM_REQ  bit-select per requester, bits [WIDTH*i +: WIDTH]; stable while req[i]=1.
- gnt  out  NUM_REQ  one-cycle completion pulse, one-hot or zero.
- busy  out  1  high while a command is in flight (APPLY or ACK).
- q  out  WIDTH  bank state.
- q_bar  out  WIDTH  always the bitwise inverse of q.

Behaviour:
- Reset is asynchronous, active-high: one clock (clk), one reset (rst). While rst=1, all of the following hold:
  - q=0, q_bar=all ones.
  - gnt=0, busy=0.
  - state=IDLE, rr_ptr=0.
  - Latched winner, cmd and mask are cleared.
- Command encoding (J,K per masked bit): 00 HOLD (J=0,K=0), 01 RESET (J=0,K=1), 10 SET (J=1,K=0), 11 TOGGLE (J=1,K=1).
- Unmasked bits always receive J=0,K=0.
- FSM states: IDLE, APPLY, ACK.
  - IDLE: if any req is high at edge E0, the winner is the first set req[] scanning from rst_ptr upward, modulo NUM_REQ. Latch winner index, cmd and mask; go to APPLY. Otherwise stay in IDLE.
  - APPLY: drive bank J/K from the latched cmd/mask for one cycle. At edge E1, q updates; go to ACK.
  - ACK: gnt[winner]=1 for this cycle only. At edge E2, go to IDLE and set rr_ptr=(winner+1) mod NUM_REQ.
- Timing:
  - q reflects the command in the cycle after E1.
  - gnt is high during the cycle between E1 and E2.
  - busy=1 exactly while in APPLY or ACK.
  - Throughput is one command per 3 cycles when back-to-back requests are pending.
- Requester rules:
  - Drop req in the cycle after its gnt is seen, or it is re-arbitrated at its new (lowest) priority.
  - Inputs are only sampled in IDLE; req, cmd and mask changes during APPLY/ACK are ignored.
  - A req withdrawn after being latched is still applied and still granted.
- HOLD, or mask=0: full handshake occurs, q unchanged.
- Async reset mid-operation (APPLY or ACK):
  - Immediate return to reset values.
  - No gnt is issued; the latched command is discarded.
  - q=0 even if E1 had already applied the command.
- Simultaneous requests: exactly one is granted per transaction. Starvation-free; worst-case wait is NUM_REQ transactions.
- q_bar is combinationally ~q; it is never X after reset.

Decomposition:
- Package jk_bank_pkg:
  - Command localparams CMD_HOLD=2'b00, CMD_RESET=2'b01, CMD_SET=2'b10, CMD_TOGGLE=2'b11.
  - FSM state encoding ST_IDLE, ST_APPLY, ST_ACK.
- Sub-module jk_ff_bank:
  - Parameter WIDTH; ports clk, rst, j[WIDTH], k[WIDTH], q[WIDTH], q_bar[WIDTH].
  - Per-bit JK flop with async active-high reset to 0.
  - The arbiter instantiates it once and owns only FSM, rr_ptr, latches and J/K decode.

Test Plan:
- Reset (NUM_REQ=4, WIDTH=8): assert rst mid-cycle -> immediately q=8'h00, q_bar=8'hFF, gnt=4'b0000, busy=0.
- req[0] SET mask 8'h0F, sampled at E0 -> q=8'h0F after E1; gnt=4'b0001 for exactly one cycle before E2; busy high for 2 cycles.
- req[1] TOGGLE mask 8'hFF from q=8'h0F -> q=8'hF0. Then req[3] RESET mask 8'hC0 -> q=8'h30; q_bar=8'hCF.
- Round-robin with all four req held continuously from rr_ptr=0, each dropped one cycle after its gnt then re-raised -> grant order 0,1,2,3,0. No requester is granted twice before all others.
- req[2] HOLD mask 8'hFF, and separately SET mask 8'h00 -> q unchanged in both cases; gnt[2] still pulses once for each.
- req[0] SET mask 8'hFF, then rst pulsed during ACK -> q=8'h00, no gnt pulse, busy=0. The next req[1] is granted with rr_ptr=0 priority.
